rv32im_muldiv: RTL and testbench
================================

RV32IM_MULDIV -- requirements
Module: rv32im_muldiv

Interface
Parameters: none; data width is `API_DATA_WIDTH (32).
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 muldiv_valid_i  input  1  request present this cycle.
REQ-005 muldiv_ready_o  output  1  block can accept a request; high only in IDLE.
REQ-006 muldiv_funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 operand_1_i  input  32  rs1 value (multiplicand / dividend).
REQ-008 operand_2_i  input  32  rs2 value (multiplier / divisor).
REQ-009 flush_i  input  1  abort in-flight operation (pipeline kill).
REQ-010 busy_o  output  1  operation in progress (CALC or DONE state).
REQ-011 result_valid_o  output  1  one-cycle pulse; result_o is valid.
REQ-012 result_o  output  32  result of the last completed operation.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 Handshake: a request SHALL be accepted on an edge with muldiv_valid_i=1 and muldiv_ready_o=1; operands and funct3 SHALL be latched on that edge, and later input changes SHALL be ignored.
REQ-015 IDLE->CALC on acceptance. The 5-bit step counter SHALL be cleared to 0.
REQ-016 CALC SHALL perform one iteration per cycle for exactly 32 cycles (counter 0..31); on the edge where counter=31, the FSM SHALL go to DONE.
REQ-017 DONE SHALL last exactly one cycle with result_valid_o=1, then go to IDLE.
REQ-018 Latency: result_valid_o SHALL be high in the 33rd cycle after the accepting edge, for every op, including special cases.
REQ-019 Multiply SHALL be an iterative shift-add over 64-bit product magnitudes. Results:
- MUL: low 32 bits.
- MULH: high 32 bits with both operands signed.
- MULHSU: high 32 bits with rs1 signed and rs2 unsigned.
- MULHU: high 32 bits with both operands unsigned.
REQ-020 Divide SHALL be a restoring division on magnitudes, one quotient bit per cycle.
- Signed ops: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-021 Divide by zero (divisor=0) SHALL give:
- DIV/DIVU: 0xFFFFFFFF.
- REM/REMU: the dividend.
REQ-022 Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF) SHALL give DIV=0x80000000 and REM=0.
REQ-023 result_o SHALL hold its value from DONE until the next DONE; it is not cleared on acceptance.
REQ-024 flush_i=1 in CALC or DONE SHALL force IDLE on the next edge, with no result_valid_o pulse and result_o unchanged.
REQ-025 flush_i=1 in IDLE SHALL block acceptance on that edge.
REQ-026 muldiv_valid_i while busy SHALL be ignored; it is not queued.
REQ-027 Back-to-back: a new request SHALL be acceptable on the edge ending the IDLE cycle that follows DONE; throughput is one op per 34 cycles.

Reset
REQ-028 On an edge with rst_i=1 the block SHALL enter IDLE, with priority over flush_i and muldiv_valid_i.
REQ-029 Reset values SHALL be: result_o=0, result_valid_o=0, busy_o=0, muldiv_ready_o=1, counter=0.
REQ-030 Reset mid-operation SHALL discard the operation with no result_valid_o pulse.

Verification
REQ-031 MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> result_valid_o 33 cycles after accept, result_o=0xFFFFFFFE; MUL on the same operands -> 0x00000001.
REQ-032 MULH, 0x80000000 x 0x80000000 -> 0x40000000; MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV, -7 / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU, 100 / 7 -> 14; REMU on the same operands -> 2.
REQ-034 DIV, 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; DIVU, 5 / 0 -> 0xFFFFFFFF; REMU, 5 / 0 -> 5.
REQ-035 Accept MUL 3x4, then assert flush_i at counter=10 -> IDLE next cycle, no pulse, result_o keeps its prior value; then MUL 3x4 again -> 12.
REQ-036 Drive muldiv_valid_i continuously with changing operands -> exactly one accept per 34 cycles, and each result matches the operands latched at its own accept; rst_i mid-CALC -> the reset values of REQ-029 on the next cycle.

Source files
------------

// File: rtl/rv32im_muldiv.sv
// rv32im_muldiv: iterative RV32M multiply/divide unit, 32 shift-add or restoring steps per op.
module rv32im_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        muldiv_valid_i,
  output logic        muldiv_ready_o,
  input  logic [2:0]  muldiv_funct3_i,
  input  logic [31:0] operand_1_i,
  input  logic [31:0] operand_2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] result_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic        neg;
  logic [63:0] acc, opa, acc_nxt, prod;
  logic [31:0] opb, a_mag, b_mag, quo, rem, res;
  logic [32:0] diff;
  logic        sa, sb, a_neg, b_neg, neg_in;
  assign sa     = muldiv_funct3_i[2] ? ~muldiv_funct3_i[0] : muldiv_funct3_i[0] ^ muldiv_funct3_i[1];
  assign sb     = muldiv_funct3_i[2] ? ~muldiv_funct3_i[0] : muldiv_funct3_i[1:0] == 2'b01;
  assign a_neg  = sa & operand_1_i[31];
  assign b_neg  = sb & operand_2_i[31];
  assign a_mag  = a_neg ? -operand_1_i : operand_1_i;
  assign b_mag  = b_neg ? -operand_2_i : operand_2_i;
  // A zero divisor must leave the all-ones quotient un-negated; remainder follows the dividend.
  assign neg_in = muldiv_funct3_i[2] ? (muldiv_funct3_i[1] ? a_neg : (a_neg ^ b_neg) & |operand_2_i)
                                     : a_neg ^ b_neg;
  // Divide keeps {remainder, quotient} in acc and shifts dividend bits up through it.
  assign diff    = acc[63:31] - {1'b0, opb};
  assign acc_nxt = op[2] ? (diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                         : acc + (opb[0] ? opa : 64'd0);
  assign prod    = neg ? -acc_nxt : acc_nxt;
  assign quo     = neg ? -acc_nxt[31:0] : acc_nxt[31:0];
  assign rem     = neg ? -acc_nxt[63:32] : acc_nxt[63:32];
  assign res     = op[2] ? (op[1] ? rem : quo) : (|op[1:0] ? prod[63:32] : prod[31:0]);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= 5'd0;
      result_o       <= 32'd0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      muldiv_ready_o <= 1'b1;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        IDLE: if (muldiv_valid_i && !flush_i) begin
          state          <= CALC;
          cnt            <= 5'd0;
          op             <= muldiv_funct3_i;
          neg            <= neg_in;
          acc            <= muldiv_funct3_i[2] ? {32'd0, a_mag} : 64'd0;
          opa            <= {32'd0, a_mag};
          opb            <= b_mag;
          busy_o         <= 1'b1;
          muldiv_ready_o <= 1'b0;
        end
        CALC: if (flush_i) begin
          state          <= IDLE;
          busy_o         <= 1'b0;
          muldiv_ready_o <= 1'b1;
        end else begin
          acc <= acc_nxt;
          opa <= opa << 1;
          opb <= op[2] ? opb : opb >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state          <= DONE;
            result_o       <= res;
            result_valid_o <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          busy_o         <= 1'b0;
          muldiv_ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32im_muldiv.sv
// tb_rv32im_muldiv: directed and random ops against an arithmetic reference model.
module tb_rv32im_muldiv;
  logic        clk = 0, rst = 1, valid = 0, flush = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] op1 = 0, op2 = 0;
  logic        ready, busy, rvalid;
  logic [31:0] result;
  int          total = 0, bad = 0;

  rv32im_muldiv dut (
    .clk_i(clk), .rst_i(rst), .muldiv_valid_i(valid), .muldiv_ready_o(ready),
    .muldiv_funct3_i(funct3), .operand_1_i(op1), .operand_2_i(op2), .flush_i(flush),
    .busy_o(busy), .result_valid_o(rvalid), .result_o(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 9);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n = 0;
    logic [31:0] e = ref_model(f, a, b);
    while (!ready && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready"}, ready, 1);
    @(negedge clk);
    valid = 1; funct3 = f; op1 = a; op2 = b;
    @(posedge clk); #1;
    valid = 0; funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
    chk({tag, "_busy"}, {busy, ready}, 2'b10);
    n = 0;
    while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, n, 32);
    chk(tag, result, e);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {rvalid, ready, busy}, 3'b010);
  endtask

  initial begin
    logic [31:0] q[$];
    int last_acc, pulses;
    logic [2:0] f;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {result, rvalid, busy, ready}, {32'd0, 3'b001});
    rst = 0;

    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_ff");
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul_ff");
    run_op(3'd1, 32'h80000000, 32'h80000000, "mulh_min");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ff");
    run_op(3'd4, -32'sd7, 32'd2, "div_m7_2");
    run_op(3'd6, -32'sd7, 32'd2, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
    run_op(3'd5, 32'd5, 32'd0, "divu_z");
    run_op(3'd7, 32'd5, 32'd0, "remu_z");
    run_op(3'd4, -32'sd9, 32'd0, "div_negz");
    run_op(3'd6, -32'sd9, 32'd0, "rem_negz");
    for (int i = 0; i < 24; i++) run_op(3'($urandom_range(0, 7)), pick(), pick(), "rand");

    // flush in IDLE blocks acceptance
    run_op(3'd0, 32'd5, 32'd5, "mul_5x5");
    @(negedge clk); valid = 1; flush = 1; funct3 = 0; op1 = 7; op2 = 7;
    @(posedge clk); #1; valid = 0; flush = 0;
    chk("idle_flush", {busy, ready}, 2'b01);

    // flush mid-CALC at counter=10
    @(negedge clk); valid = 1; funct3 = 0; op1 = 3; op2 = 4;
    @(posedge clk); #1; valid = 0;
    repeat (10) @(posedge clk);
    #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    chk("flush_state", {rvalid, busy, ready}, 3'b001);
    chk("flush_hold", result, 32'd25);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; pulses += int'(rvalid); end
    chk("flush_nopulse", pulses, 0);
    run_op(3'd0, 32'd3, 32'd4, "mul_3x4");

    // continuous valid: one accept per 34 cycles, each result from its own operands
    last_acc = -1;
    for (int c = 0; c < 34 * 6 + 40; c++) begin
      @(negedge clk);
      f = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      valid = c < 34 * 6; funct3 = f; op1 = a; op2 = b;
      if (valid && ready) begin
        q.push_back(ref_model(f, a, b));
        if (last_acc >= 0) chk("stream_gap", c - last_acc, 34);
        last_acc = c;
      end
      @(posedge clk); #1;
      if (rvalid) begin
        if (q.size() == 0) chk("stream_spurious", rvalid, 0);
        else chk("stream", result, q.pop_front());
      end
    end
    valid = 0;
    chk("stream_pending", q.size(), 0);

    // reset mid-CALC
    @(negedge clk); valid = 1; funct3 = 3'd1; op1 = $urandom; op2 = $urandom;
    @(posedge clk); #1; valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1; flush = 1; valid = 1;
    @(posedge clk); #1; rst = 0; flush = 0; valid = 0;
    chk("rst_mid", {result, rvalid, busy, ready}, {32'd0, 3'b001});
    pulses = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; pulses += int'(rvalid); end
    chk("rst_nopulse", pulses, 0);
    run_op(3'd5, 32'd100, 32'd7, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
